// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op and FSM encodings shared by the multiply/divide unit
package mdu_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    function automatic logic opIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic opIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - command, MTHI/MTLO and HI/LO result bundle of the multiply/divide unit
interface mdu_if import mdu_pkg::*; #(parameter int WIDTH = MDU_ITER);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, src_a, src_b, hi_we, lo_we, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, src_a, src_b, hi_we, lo_we, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional negation of two words, separately or as one 2*WIDTH value
module mdu_sign_fix import mdu_pkg::*; #(parameter int WIDTH = MDU_ITER) (
    input  logic [WIDTH-1:0] inHi,
    input  logic [WIDTH-1:0] inLo,
    input  logic             negHi,
    input  logic             negLo,
    input  logic             wide,
    output logic [WIDTH-1:0] outHi,
    output logic [WIDTH-1:0] outLo
);
    logic [2*WIDTH-1:0] wideVal;

    // In wide mode negHi alone controls negation of the whole {inHi, inLo} product.
    always_comb begin
        wideVal = {inHi, inLo};
        outHi   = inHi;
        outLo   = inLo;
        if (wide) begin
            if (negHi) begin
                wideVal = -wideVal;
            end
            outHi = wideVal[2*WIDTH-1:WIDTH];
            outLo = wideVal[WIDTH-1:0];
        end else begin
            if (negHi) begin
                outHi = -inHi;
            end
            if (negLo) begin
                outLo = -inLo;
            end
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO, one result bit per cycle
module mult_div_unit import mdu_pkg::*; #(parameter int WIDTH = MDU_ITER) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               isDiv;
    logic               negHi;
    logic               negLo;
    logic               divZero;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   rawA;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [2*WIDTH-1:0] acc;

    logic               signA;
    logic               signB;
    logic               startDiv;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;
    logic [WIDTH:0]     addA;
    logic [WIDTH:0]     addB;
    logic [WIDTH:0]     sum;
    logic               qBit;

    assign signA    = opIsSigned(bus.op) & bus.src_a[WIDTH-1];
    assign signB    = opIsSigned(bus.op) & bus.src_b[WIDTH-1];
    assign startDiv = opIsDiv(bus.op);

    mdu_sign_fix #(.WIDTH(WIDTH)) uEntry (
        .inHi(bus.src_a), .inLo(bus.src_b), .negHi(signA), .negLo(signB), .wide(1'b0),
        .outHi(absA), .outLo(absB)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) uExit (
        .inHi(acc[2*WIDTH-1:WIDTH]), .inLo(acc[WIDTH-1:0]), .negHi(negHi), .negLo(negLo),
        .wide(~isDiv), .outHi(fixHi), .outLo(fixLo)
    );

    // Shared adder: multiply adds the multiplicand into the high half; divide subtracts
    // the divisor from the partial remainder shifted left with the next dividend bit.
    always_comb begin
        addA = isDiv ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        addB = isDiv ? ~{1'b0, operand} : (acc[0] ? {1'b0, operand} : '0);
        sum  = addA + addB + {{WIDTH{1'b0}}, isDiv};
        qBit = ~sum[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            isDiv   <= 1'b0;
            negHi   <= 1'b0;
            negLo   <= 1'b0;
            divZero <= 1'b0;
            operand <= '0;
            rawA    <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            acc     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.start) begin
                        state   <= S_RUN;
                        isDiv   <= startDiv;
                        rawA    <= bus.src_a;
                        divZero <= startDiv && (bus.src_b == '0);
                        if (startDiv) begin
                            negHi   <= signA;
                            negLo   <= signA ^ signB;
                            acc     <= {{WIDTH{1'b0}}, absA};
                            operand <= absB;
                        end else begin
                            negHi   <= signA ^ signB;
                            negLo   <= 1'b0;
                            acc     <= {{WIDTH{1'b0}}, absB};
                            operand <= absA;
                        end
                    end else begin
                        if (bus.hi_we) hiReg <= bus.wdata;
                        if (bus.lo_we) loReg <= bus.wdata;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (isDiv) begin
                        acc <= {(qBit ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                                acc[WIDTH-2:0], qBit};
                    end else begin
                        acc <= {sum, acc[WIDTH-1:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_DONE;
                    hiReg <= divZero ? rawA : fixHi;
                    loReg <= divZero ? '1 : fixLo;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state == S_RUN) || (state == S_FIX);
    assign bus.done = (state == S_DONE);
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an op at the current negedge; returns at the negedge where done is seen.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.src_a = ~a;
        bus.src_b = b + 32'd1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int cyc;
        runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        checks++; if (cyc !== 34) begin failures++; $display("FAIL multu_latency got %0d exp 34", cyc); end
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL multu_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_signed();
        int cyc;
        runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, cyc);
        checks++; if (cyc !== 34) begin failures++; $display("FAIL mult_latency got %0d exp 34", cyc); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
        @(negedge clk);
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got %h exp fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got %h exp ffffffff", bus.hi); end
        @(negedge clk);
        runOp(OP_DIVU, 32'd100, 32'd7, cyc);
        checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL divu_lo got %h exp 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL divu_hi got %h exp 00000002", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_div_edge();
        int cyc;
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got %h exp 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got %h exp 00000000", bus.hi); end
        @(negedge clk);
        runOp(OP_DIVU, 32'd7, 32'd0, cyc);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_zero_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'd7) begin failures++; $display("FAIL divu_zero_hi got %h exp 00000007", bus.hi); end
        @(negedge clk);
        runOp(OP_DIV, 32'hFFFF_FFFB, 32'd0, cyc);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_zero_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFB) begin failures++; $display("FAIL div_zero_hi got %h exp fffffffb", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        cyc = 0;
        repeat (5) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd9;
        bus.src_b = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        checks++; if (cyc !== 34) begin failures++; $display("FAIL ignore_latency got %0d exp 34", cyc); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL ignore_hi got %h exp 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'd6) begin failures++; $display("FAIL ignore_lo got %h exp 00000006", bus.lo); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got %b exp 0", bus.busy); end
    endtask

    task automatic test_mt_write();
        int cyc;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'h1234) begin failures++; $display("FAIL mt_hi got %h exp 00001234", bus.hi); end
        checks++; if (bus.lo !== 32'h1234) begin failures++; $display("FAIL mt_lo got %h exp 00001234", bus.lo); end
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5555;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'd4;
        bus.src_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'h1234) begin failures++; $display("FAIL mt_dropped_hi got %h exp 00001234", bus.hi); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mt_start_busy got %b exp 1", bus.busy); end
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        checks++; if (cyc !== 34) begin failures++; $display("FAIL mt_start_latency got %0d exp 34", cyc); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL mt_start_hi got %h exp 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'd16) begin failures++; $display("FAIL mt_start_lo got %h exp 00000010", bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc;
        int doneSeen;
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL abort_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL abort_lo got %h exp 0", bus.lo); end
        doneSeen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
        end
        checks++; if (doneSeen !== 0) begin failures++; $display("FAIL abort_no_done got %0d exp 0", doneSeen); end
        runOp(OP_DIVU, 32'd100, 32'd7, cyc);
        checks++; if (cyc !== 34) begin failures++; $display("FAIL restart_latency got %0d exp 34", cyc); end
        checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL restart_lo got %h exp 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL restart_hi got %h exp 00000002", bus.hi); end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_multu();
        test_signed();
        test_div_edge();
        test_busy_ignore();
        test_mt_write();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
